// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: opcodes, instruction classes, FSM states.
package fetch_sequencer_pkg;

  localparam logic [5:0] OpAlu   = 6'b100000;
  localparam logic [5:0] OpLi    = 6'b111000;
  localparam logic [5:0] OpLui   = 6'b111001;
  localparam logic [5:0] OpAddi  = 6'b110000;
  localparam logic [5:0] OpNandi = 6'b110010;
  localparam logic [5:0] OpOri   = 6'b110011;
  localparam logic [5:0] OpLb    = 6'b000011;
  localparam logic [5:0] OpLw    = 6'b001111;
  localparam logic [5:0] OpSw    = 6'b011111;
  localparam logic [5:0] OpB     = 6'b111111;
  localparam logic [5:0] OpBeq   = 6'b000000;
  localparam logic [5:0] OpBne   = 6'b000001;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsImm,
    ClsLoad,
    ClsStore,
    ClsBr
  } iclass_e;

  typedef enum logic [2:0] {
    StStart  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

endpackage

// File: rtl/fetch_sequencer_opcode_classifier.sv
// Combinational opcode decode into instruction class plus branch flavour and illegal flag.
module opcode_classifier
  import fetch_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  output iclass_e    iclass_o,
  output logic       is_b_o,
  output logic       is_beq_o,
  output logic       is_bne_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o  = ClsAlu;
    is_b_o    = 1'b0;
    is_beq_o  = 1'b0;
    is_bne_o  = 1'b0;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OpAlu:                               iclass_o = ClsAlu;
      OpLi, OpLui, OpAddi, OpNandi, OpOri: iclass_o = ClsImm;
      OpLb, OpLw:                          iclass_o = ClsLoad;
      OpSw:                                iclass_o = ClsStore;
      OpB: begin
        iclass_o = ClsBr;
        is_b_o   = 1'b1;
      end
      OpBeq: begin
        iclass_o = ClsBr;
        is_beq_o = 1'b1;
      end
      OpBne: begin
        iclass_o = ClsBr;
        is_bne_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb controller driving the PC update strobes.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Instr,
  input  logic              Alu_Zero,
  input  logic              Mem_Ack,
  output logic              PC_Sel,
  output logic              PC_LdEn,
  output logic [DATA_W-1:0] PC_Immed,
  output logic [DATA_W-1:0] Instr_Reg,
  output logic              Rf_We,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic              Bus_Err,
  output logic              Illegal,
  output logic [2:0]        State
);

  localparam logic [7:0] TimeoutLim = 8'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;

  iclass_e iclass;
  logic    is_b, is_beq, is_bne, op_illegal;
  logic    taken;

  opcode_classifier u_classifier (
    .opcode_i  (instr_q[31:26]),
    .iclass_o  (iclass),
    .is_b_o    (is_b),
    .is_beq_o  (is_beq),
    .is_bne_o  (is_bne),
    .illegal_o (op_illegal)
  );

  assign taken = is_b | (is_beq & Alu_Zero) | (is_bne & ~Alu_Zero);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StStart;
      instr_q   <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    PC_LdEn   = 1'b0;
    PC_Sel    = 1'b0;
    Rf_We     = 1'b0;
    Mem_Req   = 1'b0;
    Mem_We    = 1'b0;
    Illegal   = 1'b0;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        instr_d = Instr;
        state_d = StDecode;
      end
      StDecode: begin
        if (op_illegal) begin
          Illegal = 1'b1;
          state_d = StWb;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (iclass == ClsBr) begin
          PC_LdEn = 1'b1;
          PC_Sel  = taken;
          state_d = StFetch;
        end else if (iclass == ClsLoad || iclass == ClsStore) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        Mem_Req = 1'b1;
        Mem_We  = (iclass == ClsStore);
        // An ack arriving on the limit cycle still completes the access.
        if (Mem_Ack) begin
          cnt_d = '0;
          if (iclass == ClsStore) begin
            PC_LdEn = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (cnt_q + 8'd1 == TimeoutLim) begin
          cnt_d     = '0;
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb: begin
        // Instr_Reg is stable since FETCH, so the classifier still flags the NOP here.
        Rf_We   = ~op_illegal;
        PC_LdEn = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StStart;
    endcase
  end

  assign PC_Immed  = {{(DATA_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign Instr_Reg = instr_q;
  assign Bus_Err   = bus_err_q;
  assign State     = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer plus timeout and reset corner sequences.
module tb_fetch_sequencer;

  localparam logic [2:0] SStart = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SMem = 3'd4, SHalt = 3'd6;

  logic        Clk, Reset_n, Alu_Zero, Mem_Ack;
  logic [31:0] Instr, PC_Immed, Instr_Reg;
  logic        PC_Sel, PC_LdEn, Rf_We, Mem_Req, Mem_We, Bus_Err, Illegal;
  logic [2:0]  State;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(
    .DATA_W      (32),
    .MEM_TIMEOUT (15)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Instr     (Instr),
    .Alu_Zero  (Alu_Zero),
    .Mem_Ack   (Mem_Ack),
    .PC_Sel    (PC_Sel),
    .PC_LdEn   (PC_LdEn),
    .PC_Immed  (PC_Immed),
    .Instr_Reg (Instr_Reg),
    .Rf_We     (Rf_We),
    .Mem_Req   (Mem_Req),
    .Mem_We    (Mem_We),
    .Bus_Err   (Bus_Err),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [31:0] instr;
    bit          zero;
    int          ack_wait;  // MEM cycle number carrying Mem_Ack
    bit          ack_bg;    // Mem_Ack level outside MEM
    int          lat;
    bit          sel;
    int          rf;
    int          ill;
    int          req;
    int          we;
    logic [31:0] immed;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 1, mem_n = 0, req_n = 0, we_n = 0, rf_n = 0, ill_n = 0, ill_bad = 0;
    int sel_bad = 0, lat = 0;
    logic sel_at = 1'b0;
    logic [31:0] imm_at = '0, ir_at = '0;
    bit done = 0;
    Instr    = v.instr;
    Alu_Zero = v.zero;
    check($sformatf("v%0d_entry_state", idx), 32'(State), 32'(SFetch));
    while (!done && cyc <= 40) begin
      if (State == SMem) begin
        mem_n++;
        Mem_Ack = (mem_n == v.ack_wait);
      end else begin
        Mem_Ack = v.ack_bg;
      end
      #1;
      if (Mem_Req) req_n++;
      if (Mem_We) we_n++;
      if (Rf_We) rf_n++;
      if (Illegal) begin
        ill_n++;
        if (State != SDecode) ill_bad++;
      end
      if (PC_LdEn) begin
        done   = 1;
        lat    = cyc;
        sel_at = PC_Sel;
        imm_at = PC_Immed;
        ir_at  = Instr_Reg;
      end else if (PC_Sel) begin
        sel_bad++;
      end
      @(negedge Clk);
      cyc++;
    end
    Mem_Ack = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_pc_sel", idx), 32'(sel_at), 32'(v.sel));
    check($sformatf("v%0d_rf_we_cycles", idx), 32'(rf_n), 32'(v.rf));
    check($sformatf("v%0d_illegal_pulses", idx), 32'(ill_n), 32'(v.ill));
    check($sformatf("v%0d_illegal_outside_decode", idx), 32'(ill_bad), 32'd0);
    check($sformatf("v%0d_mem_req_cycles", idx), 32'(req_n), 32'(v.req));
    check($sformatf("v%0d_mem_we_cycles", idx), 32'(we_n), 32'(v.we));
    check($sformatf("v%0d_pc_sel_without_ld", idx), 32'(sel_bad), 32'd0);
    check($sformatf("v%0d_pc_immed", idx), imm_at, v.immed);
    check($sformatf("v%0d_instr_reg", idx), ir_at, v.instr);
  endtask

  initial begin
    int ld_n, mem_n, req_n, cyc;
    Reset_n  = 1'b1;
    Instr    = '0;
    Alu_Zero = 1'b0;
    Mem_Ack  = 1'b0;

    //                 instr         z  aw  bg lat sel rf ill req we immed
    vecs[0]  = '{32'h80000000, 0, 0,  0, 4,  0, 1, 0, 0,  0, 32'h00000000};
    vecs[1]  = '{32'h80000000, 0, 0,  1, 4,  0, 1, 0, 0,  0, 32'h00000000};
    vecs[2]  = '{32'h0000FFFE, 1, 0,  0, 3,  1, 0, 0, 0,  0, 32'hFFFFFFF8};
    vecs[3]  = '{32'h0000FFFE, 0, 0,  0, 3,  0, 0, 0, 0,  0, 32'hFFFFFFF8};
    vecs[4]  = '{32'h04000010, 0, 0,  0, 3,  1, 0, 0, 0,  0, 32'h00000040};
    vecs[5]  = '{32'h04000010, 1, 0,  0, 3,  0, 0, 0, 0,  0, 32'h00000040};
    vecs[6]  = '{32'hFC000001, 1, 0,  0, 3,  1, 0, 0, 0,  0, 32'h00000004};
    vecs[7]  = '{32'hFC000001, 0, 0,  0, 3,  1, 0, 0, 0,  0, 32'h00000004};
    vecs[8]  = '{32'h7C000004, 0, 3,  0, 6,  0, 0, 0, 3,  3, 32'h00000010};
    vecs[9]  = '{32'h3C000000, 0, 1,  0, 5,  0, 1, 0, 1,  0, 32'h00000000};
    vecs[10] = '{32'h0C007FFF, 0, 2,  0, 6,  0, 1, 0, 2,  0, 32'h0001FFFC};
    vecs[11] = '{32'h3C000000, 0, 15, 0, 19, 0, 1, 0, 15, 0, 32'h00000000};
    vecs[12] = '{32'h7C00FFFF, 0, 1,  0, 4,  0, 0, 0, 1,  1, 32'hFFFFFFFC};
    vecs[13] = '{32'h14000000, 0, 0,  0, 3,  0, 0, 1, 0,  0, 32'h00000000};
    vecs[14] = '{32'h88000000, 1, 0,  0, 3,  0, 0, 1, 0,  0, 32'h00000000};
    vecs[15] = '{32'hE0000000, 0, 0,  0, 4,  0, 1, 0, 0,  0, 32'h00000000};
    vecs[16] = '{32'hE4000001, 0, 0,  0, 4,  0, 1, 0, 0,  0, 32'h00000004};
    vecs[17] = '{32'hC0008000, 0, 0,  0, 4,  0, 1, 0, 0,  0, 32'hFFFE0000};
    vecs[18] = '{32'hC8000000, 0, 0,  0, 4,  0, 1, 0, 0,  0, 32'h00000000};
    vecs[19] = '{32'hCC000000, 1, 0,  0, 4,  0, 1, 0, 0,  0, 32'h00000000};

    // Reset state and START -> FETCH after release.
    #3 Reset_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_state", 32'(State), 32'(SStart));
    check("rst_instr_reg", Instr_Reg, 32'h0);
    check("rst_strobes", {26'd0, PC_LdEn, PC_Sel, Rf_We, Mem_Req, Mem_We, Illegal}, 32'h0);
    check("rst_bus_err", 32'(Bus_Err), 32'd0);
    Reset_n = 1'b1;
    check("post_rst_start", 32'(State), 32'(SStart));
    @(negedge Clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // lw with no ack: exactly 15 MEM cycles, then sticky Bus_Err in HALT.
    check("to_entry_state", 32'(State), 32'(SFetch));
    Instr   = 32'h3C000000;
    Mem_Ack = 1'b0;
    ld_n = 0; mem_n = 0; cyc = 0;
    while (State != SHalt && cyc < 40) begin
      #1;
      if (State == SMem) mem_n++;
      if (PC_LdEn) ld_n++;
      @(negedge Clk);
      cyc++;
    end
    check("to_state_halt", 32'(State), 32'(SHalt));
    check("to_mem_cycles", 32'(mem_n), 32'd15);
    check("to_bus_err", 32'(Bus_Err), 32'd1);
    req_n = 0;
    repeat (10) begin
      Mem_Ack = 1'b1;
      #1;
      if (PC_LdEn) ld_n++;
      if (Mem_Req) req_n++;
      @(negedge Clk);
    end
    Mem_Ack = 1'b0;
    check("to_no_pc_ld", 32'(ld_n), 32'd0);
    check("to_halt_no_req", 32'(req_n), 32'd0);
    check("to_still_halt", 32'(State), 32'(SHalt));
    check("to_bus_err_sticky", 32'(Bus_Err), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("to_rst_clears_bus_err", 32'(Bus_Err), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // sw waiting in MEM, then asynchronous reset mid-wait.
    Instr = 32'h7C000004;
    cyc = 0;
    while (State != SMem && cyc < 10) begin
      @(negedge Clk);
      cyc++;
    end
    check("mr_reached_mem", 32'(State), 32'(SMem));
    repeat (4) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mr_async_state", 32'(State), 32'(SStart));
    check("mr_async_strobes", {27'd0, PC_LdEn, Rf_We, Mem_Req, Mem_We, Bus_Err}, 32'h0);
    check("mr_async_instr_reg", Instr_Reg, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ld_n = 0;
    #1;
    if (PC_LdEn) ld_n++;
    check("mr_start", 32'(State), 32'(SStart));
    @(negedge Clk);
    #1;
    if (PC_LdEn) ld_n++;
    check("mr_fetch", 32'(State), 32'(SFetch));
    check("mr_no_spurious_ld", 32'(ld_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
